// File: rtl/nios_nios2_qsys_ocimem_pkg.sv
// Shared types and JTAG data-word field positions for the on-chip debug memory controller.
package nios_nios2_qsys_ocimem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      J_RD = 2'd1,
      C_RD = 2'd2
   } ocimem_state_e;

   localparam int JDO_W         = 38;
   localparam int JDO_ADDR_LSB  = 17;
   localparam int JDO_RDFLAG    = 35;
   localparam int JDO_WDATA_MSB = 34;
   localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios_nios2_qsys_ocimem_ram.sv
// Single-port synchronous RAM holding the debug monitor image; read data appears one cycle after addr.
module nios_nios2_qsys_ocimem_ram #(
   parameter int    ADDR_W    = 8,
   parameter string INIT_FILE = ""
) (
   input  logic              clk_i,
   input  logic              wren_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       d_i,
   output logic [31:0]       q_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem_q [0:DEPTH-1];
   logic [31:0] q_q;

   // Read-before-write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (wren_i) begin
         mem_q[addr_i] <= d_i;
      end
      q_q <= mem_q[addr_i];
   end

   assign q_o = q_q;

endmodule

// File: rtl/nios_nios2_qsys_ocimem_ctrl.sv
// Debug memory controller: executes JTAG ocimem commands into MonAReg/MonDReg and shares
// the monitor RAM with the CPU debug slave, JTAG taking priority.
module nios_nios2_qsys_ocimem_ctrl
   import nios_nios2_qsys_ocimem_pkg::*;
#(
   parameter int    ADDR_W    = 8,
   parameter string INIT_FILE = ""
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [JDO_W-1:0]  jdo_i,
   input  logic              take_action_ocimem_a_i,
   input  logic              take_no_action_ocimem_a_i,
   input  logic              take_action_ocimem_b_i,
   output logic [31:0]       MonDReg_o,
   output logic              monitor_ready_o,
   output logic              monitor_error_o,
   input  logic [ADDR_W-1:0] avs_address_i,
   input  logic              avs_read_i,
   input  logic              avs_write_i,
   input  logic [31:0]       avs_writedata_i,
   output logic [31:0]       avs_readdata_o,
   output logic              avs_waitrequest_o
);

   ocimem_state_e     state_q, state_d;
   logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
   logic [31:0]       mon_dreg_q, mon_dreg_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              load_rd_q, load_rd_d;
   logic [31:0]       readdata_q, readdata_d;

   logic              ram_wren_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [31:0]       ram_d_s;
   logic [31:0]       ram_q_s;
   logic              waitreq_s;
   logic              any_take_s;
   logic [ADDR_W-1:0] jdo_addr_s;
   logic [31:0]       jdo_wdata_s;
   logic              unused_jdo_s;

   assign jdo_addr_s   = jdo_i[JDO_ADDR_LSB +: ADDR_W];
   assign jdo_wdata_s  = jdo_i[JDO_WDATA_MSB:JDO_WDATA_LSB];
   assign unused_jdo_s = ^{jdo_i[JDO_W-1:JDO_RDFLAG+1], jdo_i[JDO_WDATA_LSB-1:0]};
   assign any_take_s   = take_action_ocimem_a_i | take_no_action_ocimem_a_i | take_action_ocimem_b_i;

   nios_nios2_qsys_ocimem_ram #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk_i  (clk_i),
      .wren_i (ram_wren_s),
      .addr_i (ram_addr_s),
      .d_i    (ram_d_s),
      .q_o    (ram_q_s)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         mon_areg_q <= '0;
         mon_dreg_q <= 32'h0000_0000;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         load_rd_q  <= 1'b0;
         readdata_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         mon_areg_q <= mon_areg_d;
         mon_dreg_q <= mon_dreg_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         load_rd_q  <= load_rd_d;
         readdata_q <= readdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mon_areg_d = mon_areg_q;
      mon_dreg_d = mon_dreg_q;
      ready_d    = ready_q;
      error_d    = error_q;
      load_rd_d  = load_rd_q;
      readdata_d = readdata_q;
      ram_wren_s = 1'b0;
      ram_addr_s = mon_areg_q;
      ram_d_s    = jdo_wdata_s;
      waitreq_s  = 1'b1;
      case (state_q)
         IDLE: begin
            // Priority a > b > no_action; any losing pulse flags an error.
            if (take_action_ocimem_a_i) begin
               mon_areg_d = jdo_addr_s;
               error_d    = take_action_ocimem_b_i | take_no_action_ocimem_a_i;
               if (jdo_i[JDO_RDFLAG]) begin
                  ram_addr_s = jdo_addr_s;
                  ready_d    = 1'b0;
                  load_rd_d  = 1'b1;
                  state_d    = J_RD;
               end else begin
                  ready_d = 1'b1;
               end
            end else if (take_action_ocimem_b_i) begin
               ram_wren_s = 1'b1;
               mon_dreg_d = jdo_wdata_s;
               mon_areg_d = mon_areg_q + 1'b1;
               ready_d    = 1'b1;
               if (take_no_action_ocimem_a_i) begin
                  error_d = 1'b1;
               end else begin
                  error_d = error_q;
               end
            end else if (take_no_action_ocimem_a_i) begin
               ready_d   = 1'b0;
               load_rd_d = 1'b0;
               state_d   = J_RD;
            end else if (avs_read_i) begin
               ram_addr_s = avs_address_i;
               state_d    = C_RD;
            end else if (avs_write_i) begin
               ram_wren_s = 1'b1;
               ram_addr_s = avs_address_i;
               ram_d_s    = avs_writedata_i;
               waitreq_s  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         J_RD: begin
            mon_dreg_d = ram_q_s;
            ready_d    = 1'b1;
            if (!load_rd_q) begin
               mon_areg_d = mon_areg_q + 1'b1;
            end else begin
               mon_areg_d = mon_areg_q;
            end
            if (any_take_s) begin
               error_d = 1'b1;
            end else begin
               error_d = error_q;
            end
            state_d = IDLE;
         end
         C_RD: begin
            readdata_d = ram_q_s;
            waitreq_s  = ~avs_read_i;
            if (any_take_s) begin
               error_d = 1'b1;
            end else begin
               error_d = error_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign MonDReg_o         = mon_dreg_q;
   assign monitor_ready_o   = ready_q;
   assign monitor_error_o   = error_q;
   // Forward RAM data during the completing C_RD cycle so it is valid with waitrequest low.
   assign avs_readdata_o    = (state_q == C_RD) ? ram_q_s : readdata_q;
   assign avs_waitrequest_o = reset_i | waitreq_s;

endmodule

// File: tb/tb_nios_nios2_qsys_ocimem_ctrl.sv
// Directed self-checking bench for the on-chip debug memory controller.
module tb_nios_nios2_qsys_ocimem_ctrl;
   import nios_nios2_qsys_ocimem_pkg::*;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [JDO_W-1:0]  jdo;
   logic              take_a, take_n, take_b;
   logic [31:0]       mon_dreg;
   logic              mon_ready, mon_error;
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read, avs_write;
   logic [31:0]       avs_writedata, avs_readdata;
   logic              avs_waitrequest;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nios_nios2_qsys_ocimem_ctrl #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
      .clk_i                     (clk),
      .reset_i                   (reset),
      .jdo_i                     (jdo),
      .take_action_ocimem_a_i    (take_a),
      .take_no_action_ocimem_a_i (take_n),
      .take_action_ocimem_b_i    (take_b),
      .MonDReg_o                 (mon_dreg),
      .monitor_ready_o           (mon_ready),
      .monitor_error_o           (mon_error),
      .avs_address_i             (avs_address),
      .avs_read_i                (avs_read),
      .avs_write_i               (avs_write),
      .avs_writedata_i           (avs_writedata),
      .avs_readdata_o            (avs_readdata),
      .avs_waitrequest_o         (avs_waitrequest)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic jtag_a(input logic [ADDR_W-1:0] addr, input logic rd);
      jdo = '0;
      jdo[JDO_ADDR_LSB +: ADDR_W] = addr;
      jdo[JDO_RDFLAG] = rd;
      take_a = 1'b1;
      tick();
      take_a = 1'b0;
   endtask

   task automatic jtag_b(input logic [31:0] data);
      jdo = '0;
      jdo[JDO_WDATA_MSB:JDO_WDATA_LSB] = data;
      take_b = 1'b1;
      tick();
      take_b = 1'b0;
   endtask

   task automatic jtag_n();
      take_n = 1'b1;
      tick();
      take_n = 1'b0;
      tick();
   endtask

   task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      #1;
      chk("cpu_wr_waitreq", 32'(avs_waitrequest), 32'd0);
      tick();
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
      bit done;
      done        = 1'b0;
      avs_address = addr;
      avs_read    = 1'b1;
      for (int i = 0; i < 8 && !done; i++) begin
         #1;
         if (!avs_waitrequest) begin
            chk(tag, avs_readdata, exp);
            done = 1'b1;
         end
         tick();
      end
      avs_read = 1'b0;
      if (!done) chk({tag, "_timeout"}, 32'(avs_waitrequest), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      jdo = '0; take_a = 1'b0; take_n = 1'b0; take_b = 1'b0;
      avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'h0000_0000;
      #1;
      chk("rst_mondreg", mon_dreg, 32'h0);
      chk("rst_ready", 32'(mon_ready), 32'd0);
      chk("rst_error", 32'(mon_error), 32'd0);
      chk("rst_readdata", avs_readdata, 32'h0);
      chk("rst_waitreq", 32'(avs_waitrequest), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Load + write burst
      jtag_a(8'h10, 1'b0);
      chk("load_ready", 32'(mon_ready), 32'd1);
      chk("load_areg", 32'(dut.mon_areg_q), 32'h10);
      jtag_b(32'hA5A5_0001);
      jtag_b(32'hA5A5_0002);
      jtag_b(32'hA5A5_0003);
      chk("burst_areg", 32'(dut.mon_areg_q), 32'h13);
      chk("burst_mondreg", mon_dreg, 32'hA5A5_0003);
      cpu_read("cpu_rd_10", 8'h10, 32'hA5A5_0001);
      cpu_read("cpu_rd_11", 8'h11, 32'hA5A5_0002);
      cpu_read("cpu_rd_12", 8'h12, 32'hA5A5_0003);

      // Load-read
      cpu_write(8'h20, 32'hDEAD_BEEF);
      jtag_a(8'h20, 1'b1);
      tick();
      chk("ldrd_mondreg", mon_dreg, 32'hDEAD_BEEF);
      chk("ldrd_ready", 32'(mon_ready), 32'd1);
      chk("ldrd_areg", 32'(dut.mon_areg_q), 32'h20);

      // Address wrap
      jtag_a(8'hFF, 1'b0);
      jtag_n();
      chk("wrap_areg0", 32'(dut.mon_areg_q), 32'h00);
      jtag_n();
      chk("wrap_areg1", 32'(dut.mon_areg_q), 32'h01);
      chk("wrap_error", 32'(mon_error), 32'd0);

      // Collision during J_RD, sticky error
      take_n = 1'b1;
      tick();
      tick();
      take_n = 1'b0;
      chk("coll_error", 32'(mon_error), 32'd1);
      chk("coll_areg", 32'(dut.mon_areg_q), 32'h02);
      jtag_b(32'hCAFE_0002);
      chk("sticky_error", 32'(mon_error), 32'd1);
      chk("sticky_areg", 32'(dut.mon_areg_q), 32'h03);
      jdo = '0;
      jdo[JDO_ADDR_LSB +: ADDR_W] = 8'h50;
      take_a = 1'b1;
      take_b = 1'b1;
      tick();
      take_a = 1'b0;
      take_b = 1'b0;
      chk("simul_areg", 32'(dut.mon_areg_q), 32'h50);
      chk("simul_error", 32'(mon_error), 32'd1);
      chk("simul_mondreg", mon_dreg, 32'hCAFE_0002);
      jtag_a(8'h40, 1'b0);
      chk("clear_error", 32'(mon_error), 32'd0);

      // CPU read collides with JTAG write
      avs_address = 8'h20;
      avs_read    = 1'b1;
      jdo = '0;
      jdo[JDO_WDATA_MSB:JDO_WDATA_LSB] = 32'h1234_5678;
      take_b = 1'b1;
      #1;
      chk("arb_wait0", 32'(avs_waitrequest), 32'd1);
      tick();
      take_b = 1'b0;
      #1;
      chk("arb_wait1", 32'(avs_waitrequest), 32'd1);
      tick();
      #1;
      chk("arb_wait2", 32'(avs_waitrequest), 32'd0);
      chk("arb_rdata", avs_readdata, 32'hDEAD_BEEF);
      tick();
      avs_read = 1'b0;
      chk("arb_mondreg", mon_dreg, 32'h1234_5678);
      chk("arb_areg", 32'(dut.mon_areg_q), 32'h41);
      cpu_read("cpu_rd_40", 8'h40, 32'h1234_5678);

      // Read and write together: read wins, write does not land
      avs_writedata = 32'h0000_0000;
      avs_write     = 1'b1;
      cpu_read("rdwr_rd_20", 8'h20, 32'hDEAD_BEEF);
      avs_write = 1'b0;
      cpu_read("rdwr_chk_20", 8'h20, 32'hDEAD_BEEF);

      // Reset in the middle of J_RD
      take_n = 1'b1;
      tick();
      take_n = 1'b0;
      reset  = 1'b1;
      #1;
      chk("mid_rst_mondreg", mon_dreg, 32'h0);
      chk("mid_rst_ready", 32'(mon_ready), 32'd0);
      chk("mid_rst_error", 32'(mon_error), 32'd0);
      chk("mid_rst_readdata", avs_readdata, 32'h0);
      chk("mid_rst_waitreq", 32'(avs_waitrequest), 32'd1);
      chk("mid_rst_areg", 32'(dut.mon_areg_q), 32'h00);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("post_rst_mondreg", mon_dreg, 32'h0);
      cpu_read("post_rst_ram", 8'h11, 32'hA5A5_0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
